// File: rtl/prog_pkg.sv
// Shared constants, state encoding and error codes for the bitstream loader.
// The CRC constants are only consumed when PROG_CRC_EN is defined.
package prog_pkg;

   localparam logic [15:0] HDR_MAGIC = 16'hEF0A;
   localparam logic [31:0] CRC_POLY  = 32'h04C11DB7;
   localparam logic [31:0] CRC_INIT  = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_XOROUT = 32'hFFFFFFFF;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      LOAD,
      TRL,
      DONE,
      ERR
   } state_e;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_MAGIC = 2'b01;
   localparam logic [1:0] ERR_COUNT = 2'b10;
   localparam logic [1:0] ERR_CRC   = 2'b11;

endpackage

// File: rtl/crc32_word.sv
// Combinational CRC-32 step over one 32-bit word, MSB first, no reflection.
// Only built when PROG_CRC_EN is defined.
`ifdef PROG_CRC_EN
module crc32_word
   import prog_pkg::*;
(
   input  logic [31:0] crc_i,
   input  logic [31:0] data_i,
   output logic [31:0] crc_o
);

   logic [31:0] c;

   always_comb begin
      c = crc_i;
      for (int b = 31; b >= 0; b--) begin
         c = {c[30:0], 1'b0} ^ (CRC_POLY & {32{c[31] ^ data_i[b]}});
      end
      crc_o = c;
   end

endmodule
`endif

// File: rtl/prog_loader.sv
// Bitstream loader feeding the logic_slice programming chain.
// Define PROG_CRC_EN to add the CRC-32 trailer check (TRL state).
module prog_loader
   import prog_pkg::*;
#(
   parameter int NUM_SLICES      = 1,
   parameter int WORDS_PER_SLICE = 83
) (
   input  logic        clk,
   input  logic        res,
   input  logic        start,
   input  logic [31:0] cfg_data,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   output logic [31:0] prog_o,
   output logic        prog_shft,
   output logic        busy,
   output logic        cfg_done,
   output logic        cfg_err,
   output logic [1:0]  err_code
);

   localparam int TOTAL_WORDS = NUM_SLICES * WORDS_PER_SLICE;
   localparam int CW = $clog2(TOTAL_WORDS + 1);
   localparam logic [CW-1:0] LAST = CW'(TOTAL_WORDS - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   prog_q, prog_d;
   logic          shft_q, shft_d;
   logic [1:0]    err_q, err_d;
   logic          xfer;

   assign xfer = cfg_valid && cfg_ready;

`ifdef PROG_CRC_EN
   logic [31:0] crc_q, crc_d, crc_nxt;

   crc32_word u_crc (
      .crc_i  (crc_q),
      .data_i (cfg_data),
      .crc_o  (crc_nxt)
   );
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      prog_d  = prog_q;
      shft_d  = 1'b0;
      err_d   = err_q;
`ifdef PROG_CRC_EN
      crc_d   = crc_q;
`endif
      unique case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d = HDR;
               err_d   = ERR_NONE;
            end
         end
         HDR: begin
            if (xfer) begin
               if (cfg_data[31:16] != HDR_MAGIC) begin
                  state_d = ERR;
                  err_d   = ERR_MAGIC;
               end else if (cfg_data[15:0] != 16'(TOTAL_WORDS)) begin
                  state_d = ERR;
                  err_d   = ERR_COUNT;
               end else begin
                  state_d = LOAD;
                  cnt_d   = '0;
`ifdef PROG_CRC_EN
                  crc_d   = CRC_INIT;
`endif
               end
            end
         end
         LOAD: begin
            if (xfer) begin
               prog_d = cfg_data;
               shft_d = 1'b1;
               cnt_d  = cnt_q + CW'(1);
`ifdef PROG_CRC_EN
               crc_d  = crc_nxt;
               if (cnt_q == LAST) state_d = TRL;
`else
               if (cnt_q == LAST) state_d = DONE;
`endif
            end
         end
`ifdef PROG_CRC_EN
         TRL: begin
            if (xfer) begin
               if (cfg_data == (crc_q ^ CRC_XOROUT)) begin
                  state_d = DONE;
               end else begin
                  state_d = ERR;
                  err_d   = ERR_CRC;
               end
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (res) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         prog_q  <= '0;
         shft_q  <= 1'b0;
         err_q   <= ERR_NONE;
`ifdef PROG_CRC_EN
         crc_q   <= CRC_INIT;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prog_q  <= prog_d;
         shft_q  <= shft_d;
         err_q   <= err_d;
`ifdef PROG_CRC_EN
         crc_q   <= crc_d;
`endif
      end
   end

   // Handshake and status are pure decodes of the state register.
   assign cfg_ready = (state_q == HDR) || (state_q == LOAD) || (state_q == TRL);
   assign busy      = cfg_ready;
   assign cfg_done  = (state_q == DONE);
   assign cfg_err   = (state_q == ERR);
   assign err_code  = err_q;
   assign prog_o    = prog_q;
   assign prog_shft = shft_q;

endmodule
